// File: rtl/lsu_ctrl.sv
// Load/store unit controller: sequences word-addressed memory reads, writes and
// sub-word read-modify-writes, with big-endian byte lanes and misalignment errors.
module lsu_ctrl #(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_wdata,
  output logic        mem_R,
  output logic        mem_W,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; valid-side payload is held stable until that edge.
  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, RESP = 2'd3} state_t;

  localparam logic [2:0] OP_LW = 3'd0, OP_LH = 3'd1, OP_LHU = 3'd2, OP_LB = 3'd3,
                         OP_LBU = 3'd4, OP_SW = 3'd5, OP_SH = 3'd6, OP_SB = 3'd7;
  localparam logic [3:0] LAST = 4'(MEM_LAT - 1);

  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic        rdy_en;
  logic [2:0]  op_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        err_q;
  logic        accept, misaligned, last;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val, merged;

  assign accept = req_valid && req_ready;
  assign last   = (cnt == LAST);
  assign dbg_state = state;

  always_comb begin
    misaligned = 1'b0;
    case (req_op)
      OP_LW, OP_SW:         misaligned = (req_addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: misaligned = req_addr[0];
      default:              misaligned = 1'b0;
    endcase
  end

  // Lane select on the word read back, big-endian: offset 0 is the MSB lane.
  always_comb begin
    lane_b = 8'h00;
    case (addr_q[1:0])
      2'd0: lane_b = mem_rdata[31:24];
      2'd1: lane_b = mem_rdata[23:16];
      2'd2: lane_b = mem_rdata[15:8];
      2'd3: lane_b = mem_rdata[7:0];
      default: lane_b = 8'h00;
    endcase
    lane_h = addr_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    load_val = 32'h0;
    case (op_q)
      OP_LW:   load_val = mem_rdata;
      OP_LH:   load_val = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  load_val = {16'h0000, lane_h};
      OP_LB:   load_val = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  load_val = {24'h000000, lane_b};
      default: load_val = 32'h0;
    endcase
  end

  always_comb begin
    merged = wdata_q;
    if (op_q == OP_SH) begin
      merged = addr_q[1] ? {mem_rdata[31:16], wdata_q[15:0]} : {wdata_q[15:0], mem_rdata[15:0]};
    end else if (op_q == OP_SB) begin
      case (addr_q[1:0])
        2'd0: merged = {wdata_q[7:0], mem_rdata[23:0]};
        2'd1: merged = {mem_rdata[31:24], wdata_q[7:0], mem_rdata[15:0]};
        2'd2: merged = {mem_rdata[31:16], wdata_q[7:0], mem_rdata[7:0]};
        2'd3: merged = {mem_rdata[31:8], wdata_q[7:0]};
        default: merged = wdata_q;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) begin
        if (misaligned)            state_nx = RESP;
        else if (req_op == OP_SW)  state_nx = WR;
        else                       state_nx = RD;
      end
      RD:   if (last) state_nx = (op_q == OP_SH || op_q == OP_SB) ? WR : RESP;
      WR:   if (last) state_nx = RESP;
      RESP: if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    req_ready  = (state == IDLE) && rdy_en;
    resp_valid = (state == RESP);
    resp_rdata = (state == RESP) ? rdata_q : 32'h0;
    resp_err   = (state == RESP) && err_q;
    mem_R      = (state == RD);
    mem_W      = (state == WR);
    mem_adr    = (state == RD || state == WR) ? {2'b00, addr_q[31:2]} : 32'h0;
    mem_wdata  = (state == WR) ? wdata_q : 32'h0;
  end

  // rdy_en keeps req_ready low until the first edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      rdy_en  <= 1'b0;
      op_q    <= 3'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state  <= state_nx;
      rdy_en <= 1'b1;
      if ((state == RD || state == WR) && !last) cnt <= cnt + 4'd1;
      else                                       cnt <= 4'd0;
      if (state == IDLE && accept) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= misaligned;
        rdata_q <= 32'h0;
      end
      if (state == RD && last) begin
        if (op_q == OP_SH || op_q == OP_SB) wdata_q <= merged;
        else                                rdata_q <= load_val;
      end
    end
  end
endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl with a small word-array memory model.
module tb_lsu_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, resp_valid, resp_ready, resp_err, mem_R, mem_W;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata, resp_rdata, mem_adr, mem_wdata, mem_rdata;
  logic [1:0]  dbg_state;
  logic [31:0] mem_model [16];
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3, LBU = 3'd4,
                         SW = 3'd5, SH = 3'd6, SB = 3'd7;

  lsu_ctrl #(.MEM_LAT(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_R(mem_R), .mem_W(mem_W), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;
  assign mem_rdata = mem_model[mem_adr[3:0]];

  // Driver: issues one request and records strobe activity until resp_valid.
  task automatic run_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input bit hold, output int lat, output int rcnt, output int wcnt,
                        output int both, output int adr_bad, output logic [31:0] wlast,
                        output logic [31:0] rdata, output logic err, output bit tmo);
    logic [31:0] exp_adr;
    exp_adr = {2'b00, addr[31:2]};
    lat = 0; rcnt = 0; wcnt = 0; both = 0; adr_bad = 0; wlast = 32'h0;
    rdata = 32'hx; err = 1'bx; tmo = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd; resp_ready = !hold;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (mem_R) rcnt++;
      if (mem_W) begin wcnt++; wlast = mem_wdata; end
      if (mem_R && mem_W) both++;
      if ((mem_R || mem_W) && mem_adr !== exp_adr) adr_bad++;
      if (resp_valid) begin
        tmo = 1'b0; rdata = resp_rdata; err = resp_err;
        break;
      end
    end
    if (!hold) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    n_checks++; if ({mem_R, mem_W} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes: got %b want 00", {mem_R, mem_W}); end
    n_checks++; if (mem_adr !== 32'h0 || mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_bus: adr %h wdata %h want 0", mem_adr, mem_wdata); end
    n_checks++; if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp: rdata %h err %b want 0", resp_rdata, resp_err); end
    rst = 1'b0;
    #1;
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL release_ready_early: got %b want 0", req_ready); end
    @(posedge clk); #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_lw;
    int lat, rc, wc, bo, ab; logic [31:0] wl, rd; logic er; bit tmo;
    mem_model[5] = 32'h11223344;
    run_op(LW, 32'h14, 32'h0, 1'b0, lat, rc, wc, bo, ab, wl, rd, er, tmo);
    n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL lw_timeout: no resp_valid in 40 cycles"); end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL lw_latency: got %0d want 3", lat); end
    n_checks++; if (rc !== 2 || wc !== 0) begin n_fail++; $display("FAIL lw_strobes: R %0d W %0d want 2 0", rc, wc); end
    n_checks++; if (ab !== 0) begin n_fail++; $display("FAIL lw_mem_adr: %0d bad cycles want 0", ab); end
    n_checks++; if (rd !== 32'h11223344) begin n_fail++; $display("FAIL lw_rdata: got %h want 11223344", rd); end
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL lw_err: got %b want 0", er); end
    n_checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL lw_back_idle: ready %b valid %b want 1 0", req_ready, resp_valid); end
  endtask

  task automatic test_sub_loads;
    logic [2:0]  ops   [7] = '{LB, LBU, LH, LHU, LB, LBU, LH};
    logic [31:0] addrs [7] = '{32'h15, 32'h15, 32'h18, 32'h18, 32'h1B, 32'h1A, 32'h1A};
    logic [31:0] exps  [7] = '{32'hFFFFFFF2, 32'h000000F2, 32'hFFFF8001, 32'h00008001,
                               32'hFFFFFFFE, 32'h0000007F, 32'h00007FFE};
    int lat, rc, wc, bo, ab; logic [31:0] wl, rd, ex; logic er; bit tmo;
    mem_model[5] = 32'h11F23344;
    mem_model[6] = 32'h80017FFE;
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(exps[i]);
      run_op(ops[i], addrs[i], 32'h0, 1'b0, lat, rc, wc, bo, ab, wl, rd, er, tmo);
      ex = exp_q.pop_front();
      n_checks++; if (rd !== ex) begin n_fail++; $display("FAIL subload_rdata[%0d]: got %h want %h", i, rd, ex); end
      n_checks++; if (lat !== 3 || er !== 1'b0 || rc !== 2 || wc !== 0) begin
        n_fail++; $display("FAIL subload_timing[%0d]: lat %0d err %b R %0d W %0d want 3 0 2 0", i, lat, er, rc, wc);
      end
    end
  endtask

  task automatic test_store;
    logic [2:0]  ops   [4] = '{SB, SH, SB, SW};
    logic [31:0] addrs [4] = '{32'h17, 32'h14, 32'h14, 32'h20};
    logic [31:0] wds   [4] = '{32'h000000AB, 32'h0000BEEF, 32'hFFFFFF5A, 32'hDEADBEEF};
    logic [31:0] exps  [4] = '{32'h112233AB, 32'hBEEF3344, 32'h5A223344, 32'hDEADBEEF};
    int lats [4] = '{5, 5, 5, 3};
    int rds  [4] = '{2, 2, 2, 0};
    int lat, rc, wc, bo, ab; logic [31:0] wl, rd; logic er; bit tmo;
    mem_model[5] = 32'h11223344;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], addrs[i], wds[i], 1'b0, lat, rc, wc, bo, ab, wl, rd, er, tmo);
      n_checks++; if (wl !== exps[i]) begin n_fail++; $display("FAIL store_wdata[%0d]: got %h want %h", i, wl, exps[i]); end
      n_checks++; if (lat !== lats[i]) begin n_fail++; $display("FAIL store_latency[%0d]: got %0d want %0d", i, lat, lats[i]); end
      n_checks++; if (rc !== rds[i] || wc !== 2 || bo !== 0 || ab !== 0) begin
        n_fail++; $display("FAIL store_strobes[%0d]: R %0d W %0d both %0d badadr %0d want %0d 2 0 0", i, rc, wc, bo, ab, rds[i]);
      end
      n_checks++; if (rd !== 32'h0 || er !== 1'b0) begin n_fail++; $display("FAIL store_resp[%0d]: rdata %h err %b want 0 0", i, rd, er); end
    end
  endtask

  task automatic test_misaligned;
    logic [2:0]  ops   [5] = '{LW, SW, LH, LHU, SH};
    logic [31:0] addrs [5] = '{32'h16, 32'h21, 32'h15, 32'h13, 32'h17};
    int lat, rc, wc, bo, ab; logic [31:0] wl, rd; logic er; bit tmo;
    mem_model[5] = 32'h11223344;
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], addrs[i], 32'h12345678, 1'b0, lat, rc, wc, bo, ab, wl, rd, er, tmo);
      n_checks++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL misalign_resp[%0d]: err %b rdata %h want 1 0", i, er, rd); end
      n_checks++; if (lat !== 1 || rc !== 0 || wc !== 0) begin
        n_fail++; $display("FAIL misalign_timing[%0d]: lat %0d R %0d W %0d want 1 0 0", i, lat, rc, wc);
      end
    end
  endtask

  task automatic test_backpressure;
    int lat, rc, wc, bo, ab; logic [31:0] wl, rd; logic er; bit tmo;
    mem_model[5] = 32'hCAFEF00D;
    run_op(LW, 32'h14, 32'h0, 1'b1, lat, rc, wc, bo, ab, wl, rd, er, tmo);
    n_checks++; if (tmo !== 1'b0 || rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL bp_first: tmo %b rdata %h want 0 cafef00d", tmo, rd); end
    req_valid = 1'b1; req_op = SW; req_addr = 32'h20; req_wdata = 32'h55555555;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hCAFEF00D || resp_err !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold[%0d]: valid %b rdata %h err %b want 1 cafef00d 0", i, resp_valid, resp_rdata, resp_err);
      end
      n_checks++; if (req_ready !== 1'b0 || mem_W !== 1'b0 || mem_R !== 1'b0) begin
        n_fail++; $display("FAIL bp_ready[%0d]: ready %b R %b W %b want 0 0 0", i, req_ready, mem_R, mem_W);
      end
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL bp_release: valid %b ready %b state %0d want 0 1 0", resp_valid, req_ready, dbg_state);
    end
  endtask

  task automatic test_reset_mid;
    int w_seen;
    w_seen = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = SW; req_addr = 32'h20; req_wdata = 32'hDEADBEEF; resp_ready = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n_checks++; if (mem_W !== 1'b1) begin n_fail++; $display("FAIL rstmid_wr_entry: mem_W %b want 1", mem_W); end
    #1 rst = 1'b1;
    #1;
    n_checks++; if (mem_W !== 1'b0 || mem_wdata !== 32'h0 || mem_adr !== 32'h0) begin
      n_fail++; $display("FAIL rstmid_drop: W %b wdata %h adr %h want 0 0 0", mem_W, mem_wdata, mem_adr);
    end
    repeat (3) begin
      @(negedge clk);
      if (mem_W !== 1'b0 || mem_R !== 1'b0) w_seen++;
    end
    n_checks++; if (w_seen !== 0) begin n_fail++; $display("FAIL rstmid_quiet: %0d strobe cycles want 0", w_seen); end
    rst = 1'b0;
    #1;
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready_early: got %b want 0", req_ready); end
    @(posedge clk); #1;
    n_checks++; if (req_ready !== 1'b1 || mem_W !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready: ready %b W %b want 1 0", req_ready, mem_W); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem_model[i] = 32'h0;
    test_reset();
    test_lw();
    test_sub_loads();
    test_store();
    test_misaligned();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
